temp_alarm_hyst: RTL

Parametrised over-temperature alarm that qualifies a sampled temperature word against a high threshold with hysteresis and a persistence filter, replacing the single-threshold combinational decode. Sits between the temperature sampling path and the fan/alarm control logic. Produces a filtered level output, a one-cycle rise event and a sticky, software-clearable alarm flag.

---
 rtl/temp_alarm_hyst_pkg.sv | 25 ++
 rtl/cuenta_persist.sv | 41 ++++
 rtl/temp_alarm_hyst.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/temp_alarm_hyst_pkg.sv
// Shared definitions for the thermal alarm blocks.
// Holds the 2-bit qualifier state encoding, the default geometry of the
// temperature path and a helper that decodes the filtered level from a state.
package temp_alarm_hyst_pkg;

   // Default temperature geometry, reused by later thermal blocks.
   localparam int unsigned TEMP_W_DEF  = 6;
   localparam int unsigned T_ALTA_DEF  = 27;
   localparam int unsigned HYST_DEF    = 3;
   localparam int unsigned PERSIST_DEF = 4;

   // Qualifier states. Bit 1 set means the filtered level is high.
   typedef enum logic [1:0] {
      StNormal     = 2'd0,
      StPendAlta   = 2'd1,
      StAlta       = 2'd2,
      StPendNormal = 2'd3
   } alarm_state_e;

   // Filtered level is high while in the alarm state or while pending release.
   function automatic logic is_alta(alarm_state_e s);
      return (s == StAlta) || (s == StPendNormal);
   endfunction

endpackage

// File: rtl/cuenta_persist.sv
// Saturating run counter for the persistence filter.
// Counts consecutive qualifying samples; clr has priority over inc.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   inc         count one more qualifying sample
//   clr         restart the run from zero
//   reach_next  the next inc completes a run of PERSIST samples
module cuenta_persist #(
   parameter int unsigned PERSIST = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic clr,
   output logic reach_next
);

   localparam int unsigned CNT_W = $clog2(PERSIST + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (32'(cnt_q) < PERSIST)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign reach_next = ((32'(cnt_q) + 32'd1) == PERSIST);

endmodule

// File: rtl/temp_alarm_hyst.sv
// Over-temperature alarm with hysteresis and a persistence filter.
// A sample is hot when temp > T_ALTA and cool when temp <= T_ALTA - HYST.
// PERSIST consecutive valid qualifying samples are needed to change level;
// idle cycles (temp_valid low) neither advance nor break a run.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset
//   temp_valid     temp carries a new sample this cycle
//   temp           unsigned temperature sample
//   clr_latch      clears alarm_latched (a simultaneous rise wins)
//   temp_alta      filtered over-temperature level
//   alarm_rise     one-cycle pulse on the 0->1 edge of temp_alta
//   alarm_latched  sticky alarm flag
module temp_alarm_hyst
   import temp_alarm_hyst_pkg::*;
#(
   parameter int unsigned TEMP_W  = TEMP_W_DEF,
   parameter int unsigned T_ALTA  = T_ALTA_DEF,
   parameter int unsigned HYST    = HYST_DEF,
   parameter int unsigned PERSIST = PERSIST_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              temp_valid,
   input  logic [TEMP_W-1:0] temp,
   input  logic              clr_latch,
   output logic              temp_alta,
   output logic              alarm_rise,
   output logic              alarm_latched
);

   if (HYST > T_ALTA) begin : g_bad_hyst
      $error("temp_alarm_hyst: HYST must not exceed T_ALTA");
   end
   if (64'(T_ALTA) >= ((64'd1 << TEMP_W) - 64'd1)) begin : g_bad_alta
      $error("temp_alarm_hyst: T_ALTA must be below the largest temp code");
   end
   if ((PERSIST < 1) || (PERSIST > 255)) begin : g_bad_persist
      $error("temp_alarm_hyst: PERSIST must be in 1..255");
   end

   localparam logic [TEMP_W-1:0] TAlta = TEMP_W'(T_ALTA);
   localparam logic [TEMP_W-1:0] TBaja = TEMP_W'(T_ALTA - HYST);

   alarm_state_e state_q, state_d;
   logic         rise_q, rise_d;
   logic         latched_q, latched_d;
   logic         cnt_inc, cnt_clr, reach_next;
   logic         hot, cool;

   assign hot  = temp_valid && (temp > TAlta);
   assign cool = temp_valid && (temp <= TBaja);

   cuenta_persist #(
      .PERSIST (PERSIST)
   ) u_cuenta (
      .clk        (clk),
      .rst_n      (rst_n),
      .inc        (cnt_inc),
      .clr        (cnt_clr),
      .reach_next (reach_next)
   );

   // State register together with the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StNormal;
         rise_q    <= 1'b0;
         latched_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rise_q    <= rise_d;
         latched_q <= latched_d;
      end
   end

   // Next-state logic. The counter is zero on entry to every stable state,
   // so reach_next in a stable state means PERSIST == 1 and the pending
   // state is skipped.
   always_comb begin
      state_d = state_q;
      cnt_inc = 1'b0;
      cnt_clr = 1'b0;
      unique case (state_q)
         StNormal: begin
            if (hot) begin
               if (reach_next) begin
                  state_d = StAlta;
                  cnt_clr = 1'b1;
               end else begin
                  state_d = StPendAlta;
                  cnt_inc = 1'b1;
               end
            end else if (temp_valid) begin
               cnt_clr = 1'b1;
            end
         end
         StPendAlta: begin
            if (hot) begin
               if (reach_next) begin
                  state_d = StAlta;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if (temp_valid) begin
               state_d = StNormal;
               cnt_clr = 1'b1;
            end
         end
         StAlta: begin
            if (cool) begin
               if (reach_next) begin
                  state_d = StNormal;
                  cnt_clr = 1'b1;
               end else begin
                  state_d = StPendNormal;
                  cnt_inc = 1'b1;
               end
            end else if (temp_valid) begin
               cnt_clr = 1'b1;
            end
         end
         StPendNormal: begin
            if (cool) begin
               if (reach_next) begin
                  state_d = StNormal;
                  cnt_clr = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end else if (temp_valid) begin
               state_d = StAlta;
               cnt_clr = 1'b1;
            end
         end
         default: begin
            state_d = StNormal;
            cnt_clr = 1'b1;
         end
      endcase
   end

   // Output logic: rise is the level edge seen one cycle early so that the
   // pulse lines up with the first high cycle of temp_alta; a rise beats a clear.
   always_comb begin
      rise_d    = is_alta(state_d) && !is_alta(state_q);
      latched_d = rise_d || (latched_q && !clr_latch);
   end

   assign temp_alta     = is_alta(state_q);
   assign alarm_rise    = rise_q;
   assign alarm_latched = latched_q;

endmodule
